// File: rtl/vga_timing_pkg.sv
// Shared constants for the VGA timing generator: config register map,
// default 800x525 timing and the region index used by the axis decoder.
package vga_timing_pkg;

  localparam logic [3:0] CFG_HLB      = 4'd0;
  localparam logic [3:0] CFG_HVID     = 4'd1;
  localparam logic [3:0] CFG_HRB      = 4'd2;
  localparam logic [3:0] CFG_HFP      = 4'd3;
  localparam logic [3:0] CFG_HS       = 4'd4;
  localparam logic [3:0] CFG_HBP      = 4'd5;
  localparam logic [3:0] CFG_VTB      = 4'd6;
  localparam logic [3:0] CFG_VVID     = 4'd7;
  localparam logic [3:0] CFG_VBB      = 4'd8;
  localparam logic [3:0] CFG_VFP      = 4'd9;
  localparam logic [3:0] CFG_VS       = 4'd10;
  localparam logic [3:0] CFG_VBP      = 4'd11;
  localparam logic [3:0] CFG_IRQ_LINE = 4'd12;
  localparam logic [3:0] CFG_POLARITY = 4'd13;

  localparam int DEF_HLB  = 64;
  localparam int DEF_HVID = 512;
  localparam int DEF_HRB  = 64;
  localparam int DEF_HFP  = 16;
  localparam int DEF_HS   = 96;
  localparam int DEF_HBP  = 48;
  localparam int DEF_VTB  = 48;
  localparam int DEF_VVID = 384;
  localparam int DEF_VBB  = 48;
  localparam int DEF_VFP  = 10;
  localparam int DEF_VS   = 2;
  localparam int DEF_VBP  = 33;

  typedef enum logic [2:0] {
    RGN_BDR_A,
    RGN_VID,
    RGN_BDR_B,
    RGN_FP,
    RGN_SYNC,
    RGN_BP
  } region_e;

endpackage

// File: rtl/vga_timing_axis.sv
// One timing axis: counter with wrap, active width set (loaded at frame wrap)
// and a six-region decode of the counter's next value.
module vga_timing_axis
  import vga_timing_pkg::*;
#(
  parameter int W  = 11,
  parameter int W0 = DEF_HLB,
  parameter int W1 = DEF_HVID,
  parameter int W2 = DEF_HRB,
  parameter int W3 = DEF_HFP,
  parameter int W4 = DEF_HS,
  parameter int W5 = DEF_HBP
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         adv,
  input  logic         ld,
  input  logic [W-1:0] w_sh [6],
  output logic [W-1:0] cnt,
  output logic [W-1:0] cnt_nxt,
  output logic         last,
  output logic         vid_n,
  output logic         vis_n,
  output logic         sync_n,
  output logic [W-1:0] off_n
);

  localparam logic [W:0] ONE = (W+1)'(1);

  logic [W-1:0] w_act [6];
  logic [W-1:0] w_nxt [6];
  logic [W:0]   total;
  logic [W:0]   bnd [6];
  logic         over;
  region_e      rgn;

  always_comb begin
    total = '0;
    for (int i = 0; i < 6; i++) total = total + {1'b0, w_act[i]};
  end

  assign last = ({1'b0, cnt} == total - ONE);
  assign over = ({1'b0, cnt} >  total - ONE);

  always_comb begin
    for (int i = 0; i < 6; i++) w_nxt[i] = ld ? w_sh[i] : w_act[i];
    if (over || (adv && last)) cnt_nxt = '0;
    else if (adv)              cnt_nxt = cnt + W'(1);
    else                       cnt_nxt = cnt;
  end

  // Decode the value the counter takes next, under the widths it will use,
  // so the registered flags line up with the counter in the same cycle.
  always_comb begin
    logic [W:0] acc;
    logic [W:0] c;
    acc = '0;
    for (int i = 0; i < 6; i++) begin
      acc    = acc + {1'b0, w_nxt[i]};
      bnd[i] = acc;
    end
    c = {1'b0, cnt_nxt};
    if      (c < bnd[0]) rgn = RGN_BDR_A;
    else if (c < bnd[1]) rgn = RGN_VID;
    else if (c < bnd[2]) rgn = RGN_BDR_B;
    else if (c < bnd[3]) rgn = RGN_FP;
    else if (c < bnd[4]) rgn = RGN_SYNC;
    else                 rgn = RGN_BP;
    vid_n  = (rgn == RGN_VID);
    vis_n  = (rgn inside {RGN_BDR_A, RGN_VID, RGN_BDR_B});
    sync_n = (rgn == RGN_SYNC);
    off_n  = vid_n ? (cnt_nxt - w_nxt[0]) : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      w_act[0] <= W'(W0);
      w_act[1] <= W'(W1);
      w_act[2] <= W'(W2);
      w_act[3] <= W'(W3);
      w_act[4] <= W'(W4);
      w_act[5] <= W'(W5);
    end else begin
      cnt <= cnt_nxt;
      if (ld) for (int i = 0; i < 6; i++) w_act[i] <= w_sh[i];
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Programmable VGA timing generator with shadowed config applied at frame wrap.
// Optional line interrupt enabled by defining VGA_TIMING_LINE_IRQ_EN.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int HC_BITS = 11,
  parameter int VC_BITS = 10,
  parameter int HLB  = DEF_HLB,
  parameter int HVID = DEF_HVID,
  parameter int HRB  = DEF_HRB,
  parameter int HFP  = DEF_HFP,
  parameter int HS   = DEF_HS,
  parameter int HBP  = DEF_HBP,
  parameter int VTB  = DEF_VTB,
  parameter int VVID = DEF_VVID,
  parameter int VBB  = DEF_VBB,
  parameter int VFP  = DEF_VFP,
  parameter int VS   = DEF_VS,
  parameter int VBP  = DEF_VBP,
  parameter bit HS_POL = 1'b0,
  parameter bit VS_POL = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_wr,
  input  logic [3:0]         cfg_addr,
  input  logic [HC_BITS-1:0] cfg_data,
  input  logic               cfg_commit,
  output logic               cfg_pending,
  output logic               cfg_err,
  output logic               hsync,
  output logic               vsync,
  output logic [HC_BITS-1:0] col,
  output logic [VC_BITS-1:0] row,
  output logic               col_last,
  output logic               row_last,
  output logic               vid_active,
  output logic               bdr_active,
  output logic               frame_start,
  output logic [HC_BITS-1:0] vid_x,
  output logic [VC_BITS-1:0] vid_y,
  output logic               line_irq
);

  logic [HC_BITS-1:0] sh_h [6];
  logic [VC_BITS-1:0] sh_v [6];
  logic [1:0]         sh_pol, pol_act, pol_nxt;
  logic [HC_BITS:0]   h_sum;
  logic [VC_BITS:0]   v_sum;
  logic               cfg_ok, apply, v_last;
  logic [HC_BITS-1:0] col_nxt, h_off_n;
  logic [VC_BITS-1:0] row_nxt, v_off_n;
  logic               h_vid_n, h_vis_n, h_sync_n, v_vid_n, v_vis_n, v_sync_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_h[0] <= HC_BITS'(HLB);  sh_h[1] <= HC_BITS'(HVID); sh_h[2] <= HC_BITS'(HRB);
      sh_h[3] <= HC_BITS'(HFP);  sh_h[4] <= HC_BITS'(HS);   sh_h[5] <= HC_BITS'(HBP);
      sh_v[0] <= VC_BITS'(VTB);  sh_v[1] <= VC_BITS'(VVID); sh_v[2] <= VC_BITS'(VBB);
      sh_v[3] <= VC_BITS'(VFP);  sh_v[4] <= VC_BITS'(VS);   sh_v[5] <= VC_BITS'(VBP);
      sh_pol  <= {VS_POL, HS_POL};
    end else if (cfg_wr) begin
      if (cfg_addr <= CFG_HBP)            sh_h[cfg_addr[2:0]] <= cfg_data;
      else if (cfg_addr <= CFG_VBP)       sh_v[3'(cfg_addr - CFG_VTB)] <= cfg_data[VC_BITS-1:0];
      else if (cfg_addr == CFG_POLARITY)  sh_pol <= cfg_data[1:0];
    end
  end

  // Sums are one bit wider than the counters; a carry out saturates to
  // all-ones, which is always above the legal 2^N limit.
  always_comb begin
    logic [HC_BITS+1:0] th;
    logic [VC_BITS+1:0] tv;
    h_sum = '0;
    v_sum = '0;
    for (int i = 0; i < 6; i++) begin
      th    = {1'b0, h_sum} + {2'b00, sh_h[i]};
      h_sum = th[HC_BITS+1] ? '1 : th[HC_BITS:0];
      tv    = {1'b0, v_sum} + {2'b00, sh_v[i]};
      v_sum = tv[VC_BITS+1] ? '1 : tv[VC_BITS:0];
    end
    cfg_ok = (h_sum <= {1'b1, {HC_BITS{1'b0}}}) && (h_sum >= (HC_BITS+1)'(2)) &&
             (v_sum <= {1'b1, {VC_BITS{1'b0}}}) && (v_sum >= (VC_BITS+1)'(2));
  end

  assign row_last = col_last & v_last;
  assign apply    = cfg_pending & row_last;
  assign pol_nxt  = apply ? sh_pol : pol_act;

  // A commit landing on the wrap cycle re-arms pending, so it waits a frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cfg_pending <= 1'b0;
      cfg_err     <= 1'b0;
      pol_act     <= {VS_POL, HS_POL};
    end else begin
      if (cfg_commit && cfg_ok) cfg_pending <= 1'b1;
      else if (apply)           cfg_pending <= 1'b0;
      cfg_err <= cfg_commit & ~cfg_ok;
      pol_act <= pol_nxt;
    end
  end

  vga_timing_axis #(
    .W(HC_BITS), .W0(HLB), .W1(HVID), .W2(HRB), .W3(HFP), .W4(HS), .W5(HBP)
  ) u_h (
    .clk(clk), .reset(reset), .adv(1'b1), .ld(apply), .w_sh(sh_h),
    .cnt(col), .cnt_nxt(col_nxt), .last(col_last),
    .vid_n(h_vid_n), .vis_n(h_vis_n), .sync_n(h_sync_n), .off_n(h_off_n)
  );

  vga_timing_axis #(
    .W(VC_BITS), .W0(VTB), .W1(VVID), .W2(VBB), .W3(VFP), .W4(VS), .W5(VBP)
  ) u_v (
    .clk(clk), .reset(reset), .adv(col_last), .ld(apply), .w_sh(sh_v),
    .cnt(row), .cnt_nxt(row_nxt), .last(v_last),
    .vid_n(v_vid_n), .vis_n(v_vis_n), .sync_n(v_sync_n), .off_n(v_off_n)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      vid_active  <= 1'b0;
      bdr_active  <= 1'b0;
      frame_start <= 1'b0;
      vid_x       <= '0;
      vid_y       <= '0;
    end else begin
      hsync       <= pol_nxt[0] ? h_sync_n : ~h_sync_n;
      vsync       <= pol_nxt[1] ? v_sync_n : ~v_sync_n;
      vid_active  <= h_vid_n & v_vid_n;
      bdr_active  <= h_vis_n & v_vis_n & ~(h_vid_n & v_vid_n);
      frame_start <= (col_nxt == '0) && (row_nxt == '0);
      vid_x       <= (h_vid_n & v_vid_n) ? h_off_n : '0;
      vid_y       <= (h_vid_n & v_vid_n) ? v_off_n : '0;
    end
  end

`ifdef VGA_TIMING_LINE_IRQ_EN
  logic [VC_BITS-1:0] sh_irq, irq_act, irq_nxt;

  assign irq_nxt = apply ? sh_irq : irq_act;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_irq   <= '1;
      irq_act  <= '1;
      line_irq <= 1'b0;
    end else begin
      if (cfg_wr && cfg_addr == CFG_IRQ_LINE) sh_irq <= cfg_data[VC_BITS-1:0];
      irq_act  <= irq_nxt;
      line_irq <= (col_nxt == '0) && (row_nxt == irq_nxt);
    end
  end
`else
  assign line_irq = 1'b0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen using a scaled 32x14 timing so whole
// frames fit in a short run; HC/VC widths keep their default sizes.
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  localparam int HCB = 11;
  localparam int VCB = 10;
`ifdef VGA_TIMING_LINE_IRQ_EN
  localparam int IRQ_EXP = 1;
`else
  localparam int IRQ_EXP = 0;
`endif

  logic           clk, reset, cfg_wr, cfg_commit;
  logic [3:0]     cfg_addr;
  logic [HCB-1:0] cfg_data;
  logic           cfg_pending, cfg_err, hsync, vsync;
  logic [HCB-1:0] col, vid_x;
  logic [VCB-1:0] row, vid_y;
  logic           col_last, row_last, vid_active, bdr_active, frame_start, line_irq;

  int checks = 0;
  int failures = 0;

  vga_timing_gen #(
    .HC_BITS(HCB), .VC_BITS(VCB),
    .HLB(4), .HVID(16), .HRB(4), .HFP(2), .HS(3), .HBP(3),
    .VTB(2), .VVID(6), .VBB(2), .VFP(1), .VS(1), .VBP(2),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut (
    .clk(clk), .reset(reset), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .cfg_commit(cfg_commit), .cfg_pending(cfg_pending),
    .cfg_err(cfg_err), .hsync(hsync), .vsync(vsync), .col(col), .row(row),
    .col_last(col_last), .row_last(row_last), .vid_active(vid_active),
    .bdr_active(bdr_active), .frame_start(frame_start), .vid_x(vid_x),
    .vid_y(vid_y), .line_irq(line_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "watchdog");
  end

  task automatic goto_pos(input int c, input int r, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (col == c && row == r) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic cfg_write(input logic [3:0] a, input int d);
    cfg_wr = 1'b1; cfg_addr = a; cfg_data = HCB'(d);
    @(negedge clk);
    cfg_wr = 1'b0;
  endtask

  task automatic commit();
    cfg_commit = 1'b1;
    @(negedge clk);
    cfg_commit = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; cfg_wr = 1'b0; cfg_commit = 1'b0; cfg_addr = '0; cfg_data = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({col, row} !== '0) begin failures++; $display("FAIL rst_pos got col=%0d row=%0d exp 0 0", col, row); end
    checks++;
    if ({vid_active, bdr_active, frame_start, line_irq, col_last, row_last} !== 6'b0) begin
      failures++; $display("FAIL rst_flags got %b exp 000000",
        {vid_active, bdr_active, frame_start, line_irq, col_last, row_last});
    end
    checks++;
    if ({hsync, vsync} !== 2'b11) begin failures++; $display("FAIL rst_sync got %b exp 11", {hsync, vsync}); end
    checks++;
    if ({vid_x, vid_y} !== '0) begin failures++; $display("FAIL rst_vxy got %0d %0d exp 0 0", vid_x, vid_y); end
    checks++;
    if ({cfg_pending, cfg_err} !== 2'b00) begin failures++; $display("FAIL rst_cfg got %b exp 00", {cfg_pending, cfg_err}); end
    reset = 1'b0;
    #1;
    checks++;
    if ({col, bdr_active, frame_start, hsync} !== {HCB'(0), 1'b0, 1'b0, 1'b1}) begin
      failures++; $display("FAIL first_cycle got col=%0d bdr=%b fs=%b hs=%b exp 0 0 0 1", col, bdr_active, frame_start, hsync);
    end
    @(negedge clk);
    checks++;
    if ({col, bdr_active, vid_active} !== {HCB'(1), 1'b1, 1'b0}) begin
      failures++; $display("FAIL col1_decode got col=%0d bdr=%b vid=%b exp 1 1 0", col, bdr_active, vid_active);
    end
  endtask

  task automatic test_hline();
    bit ok;
    logic e_vid, e_bdr, e_hs, e_last;
    logic [HCB-1:0] e_x;
    goto_pos(0, 2, ok);
    for (int c = 0; c < 32; c++) begin
      e_vid  = (c >= 4 && c <= 19);
      e_bdr  = (c < 4) || (c >= 20 && c <= 23);
      e_hs   = !(c >= 26 && c <= 28);
      e_last = (c == 31);
      e_x    = e_vid ? HCB'(c - 4) : '0;
      checks++;
      if (!ok || {col, vid_active, bdr_active, hsync, col_last, vid_x, vid_y, vsync} !==
                 {HCB'(c), e_vid, e_bdr, e_hs, e_last, e_x, VCB'(0), 1'b1}) begin
        failures++;
        $display("FAIL hline c=%0d got col=%0d vid=%b bdr=%b hs=%b last=%b x=%0d y=%0d vs=%b exp vid=%b bdr=%b hs=%b last=%b x=%0d y=0 vs=1",
          c, col, vid_active, bdr_active, hsync, col_last, vid_x, vid_y, vsync, e_vid, e_bdr, e_hs, e_last, e_x);
      end
      if (c < 31) @(negedge clk);
    end
  endtask

  task automatic test_vcol();
    bit ok;
    logic e_vid, e_bdr, e_vs;
    logic [VCB-1:0] e_y;
    for (int r = 0; r < 14; r++) begin
      goto_pos(4, r, ok);
      e_vid = (r >= 2 && r <= 7);
      e_bdr = (r <= 9) && !e_vid;
      e_vs  = (r != 11);
      e_y   = e_vid ? VCB'(r - 2) : '0;
      checks++;
      if ({ok, vid_active, bdr_active, vsync, vid_y, vid_x, row_last} !==
          {1'b1, e_vid, e_bdr, e_vs, e_y, HCB'(0), 1'b0}) begin
        failures++;
        $display("FAIL vcol r=%0d got ok=%b vid=%b bdr=%b vs=%b y=%0d x=%0d rl=%b exp 1 %b %b %b %0d 0 0",
          r, ok, vid_active, bdr_active, vsync, vid_y, vid_x, row_last, e_vid, e_bdr, e_vs, e_y);
      end
    end
    goto_pos(31, 13, ok);
    checks++;
    if ({ok, col_last, row_last} !== 3'b111) begin
      failures++; $display("FAIL frame_wrap_flags got ok=%b cl=%b rl=%b exp 111", ok, col_last, row_last);
    end
  endtask

  task automatic test_frame_start();
    bit ok;
    int n;
    goto_pos(0, 0, ok);
    checks++;
    if (!ok || frame_start !== 1'b1) begin failures++; $display("FAIL fs_at_origin got %b exp 1", frame_start); end
    @(negedge clk);
    n = 1;
    checks++;
    if (frame_start !== 1'b0) begin failures++; $display("FAIL fs_width got %b exp 0", frame_start); end
    while (!frame_start && n < 1000) begin @(negedge clk); n++; end
    checks++;
    if (n != 448 || col != 0 || row != 0) begin
      failures++; $display("FAIL fs_period got %0d at col=%0d row=%0d exp 448 at 0 0", n, col, row);
    end
  endtask

  task automatic test_bad_commit();
    bit ok;
    cfg_write(CFG_HBP, 2047);
    commit();
    checks++;
    if ({cfg_err, cfg_pending} !== 2'b10) begin failures++; $display("FAIL bad_h_err got err=%b pend=%b exp 1 0", cfg_err, cfg_pending); end
    @(negedge clk);
    checks++;
    if ({cfg_err, cfg_pending} !== 2'b00) begin failures++; $display("FAIL bad_h_pulse got err=%b pend=%b exp 0 0", cfg_err, cfg_pending); end
    cfg_write(CFG_HBP, 3);
    cfg_write(CFG_VBP, 1023);
    commit();
    checks++;
    if ({cfg_err, cfg_pending} !== 2'b10) begin failures++; $display("FAIL bad_v_err got err=%b pend=%b exp 1 0", cfg_err, cfg_pending); end
    cfg_write(CFG_VBP, 2);
    goto_pos(31, 0, ok);
    checks++;
    if ({ok, col_last} !== 2'b11) begin failures++; $display("FAIL bad_unchanged got ok=%b cl=%b exp 11", ok, col_last); end
    @(negedge clk);
    checks++;
    if (col != 0 || row != 1) begin failures++; $display("FAIL bad_wrap got col=%0d row=%0d exp 0 1", col, row); end
  endtask

  task automatic test_commit();
    bit ok;
    cfg_write(CFG_HVID, 20);
    cfg_write(CFG_HLB, 0);
    goto_pos(10, 5, ok);
    commit();
    checks++;
    if (!ok || cfg_pending !== 1'b1) begin failures++; $display("FAIL cm_pending got %b exp 1", cfg_pending); end
    goto_pos(2, 6, ok);
    checks++;
    if ({ok, vid_active, cfg_pending} !== 3'b101) begin
      failures++; $display("FAIL cm_hold got ok=%b vid=%b pend=%b exp 1 0 1", ok, vid_active, cfg_pending);
    end
    goto_pos(31, 13, ok);
    checks++;
    if ({ok, cfg_pending} !== 2'b11) begin failures++; $display("FAIL cm_pre_wrap got ok=%b pend=%b exp 11", ok, cfg_pending); end
    @(negedge clk);
    checks++;
    if (col != 0 || row != 0 || cfg_pending !== 1'b0) begin
      failures++; $display("FAIL cm_clear got col=%0d row=%0d pend=%b exp 0 0 0", col, row, cfg_pending);
    end
    goto_pos(0, 2, ok);
    checks++;
    if ({ok, vid_active, vid_x} !== {2'b11, HCB'(0)}) begin failures++; $display("FAIL cm_col0 got vid=%b x=%0d exp 1 0", vid_active, vid_x); end
    goto_pos(19, 2, ok);
    checks++;
    if ({ok, vid_active, vid_x} !== {2'b11, HCB'(19)}) begin failures++; $display("FAIL cm_col19 got vid=%b x=%0d exp 1 19", vid_active, vid_x); end
    goto_pos(20, 2, ok);
    checks++;
    if ({ok, vid_active, bdr_active} !== 3'b101) begin failures++; $display("FAIL cm_col20 got vid=%b bdr=%b exp 0 1", vid_active, bdr_active); end
    goto_pos(26, 2, ok);
    checks++;
    if ({ok, hsync} !== 2'b10) begin failures++; $display("FAIL cm_hsync got %b exp 0", hsync); end
  endtask

  task automatic test_commit_on_wrap();
    bit ok;
    cfg_write(CFG_HVID, 16);
    cfg_write(CFG_HLB, 4);
    goto_pos(31, 13, ok);
    commit();
    checks++;
    if (!ok || col != 0 || row != 0 || cfg_pending !== 1'b1) begin
      failures++; $display("FAIL wrap_commit got col=%0d row=%0d pend=%b exp 0 0 1", col, row, cfg_pending);
    end
    goto_pos(0, 2, ok);
    checks++;
    if ({ok, vid_active} !== 2'b11) begin failures++; $display("FAIL wrap_deferred got vid=%b exp 1", vid_active); end
    goto_pos(31, 13, ok);
    @(negedge clk);
    checks++;
    if (!ok || cfg_pending !== 1'b0) begin failures++; $display("FAIL wrap_applied_pend got %b exp 0", cfg_pending); end
    goto_pos(0, 2, ok);
    checks++;
    if ({ok, vid_active, bdr_active} !== 3'b101) begin failures++; $display("FAIL wrap_new_col0 got vid=%b bdr=%b exp 0 1", vid_active, bdr_active); end
    goto_pos(4, 2, ok);
    checks++;
    if ({ok, vid_active, vid_x} !== {2'b11, HCB'(0)}) begin failures++; $display("FAIL wrap_new_col4 got vid=%b x=%0d exp 1 0", vid_active, vid_x); end
  endtask

  task automatic test_polarity();
    bit ok;
    cfg_write(CFG_POLARITY, 3);
    goto_pos(0, 3, ok);
    commit();
    goto_pos(27, 3, ok);
    checks++;
    if ({ok, hsync} !== 2'b10) begin failures++; $display("FAIL pol_old got hs=%b exp 0", hsync); end
    goto_pos(0, 0, ok);
    checks++;
    if ({ok, hsync, vsync} !== 3'b100) begin failures++; $display("FAIL pol_idle got hs=%b vs=%b exp 0 0", hsync, vsync); end
    goto_pos(27, 0, ok);
    checks++;
    if ({ok, hsync} !== 2'b11) begin failures++; $display("FAIL pol_hs_active got %b exp 1", hsync); end
    goto_pos(27, 11, ok);
    checks++;
    if ({ok, hsync, vsync} !== 3'b111) begin failures++; $display("FAIL pol_both got hs=%b vs=%b exp 1 1", hsync, vsync); end
    goto_pos(5, 12, ok);
    checks++;
    if ({ok, hsync, vsync} !== 3'b100) begin failures++; $display("FAIL pol_bp got hs=%b vs=%b exp 0 0", hsync, vsync); end
  endtask

  task automatic test_line_irq();
    bit ok;
    int n, pc, pr;
    goto_pos(0, 0, ok);
    n = 0;
    for (int i = 0; i < 448; i++) begin if (line_irq) n++; @(negedge clk); end
    checks++;
    if (!ok || n != 0) begin failures++; $display("FAIL irq_default got %0d pulses exp 0", n); end
    cfg_write(CFG_IRQ_LINE, 5);
    commit();
    goto_pos(0, 0, ok);
    n = 0; pc = -1; pr = -1;
    for (int i = 0; i < 448; i++) begin
      if (line_irq) begin n++; pc = int'(col); pr = int'(row); end
      @(negedge clk);
    end
    checks++;
    if (!ok || n != IRQ_EXP) begin failures++; $display("FAIL irq_count got %0d exp %0d", n, IRQ_EXP); end
`ifdef VGA_TIMING_LINE_IRQ_EN
    checks++;
    if (pc != 0 || pr != 5) begin failures++; $display("FAIL irq_pos got col=%0d row=%0d exp 0 5", pc, pr); end
`endif
    cfg_write(CFG_IRQ_LINE, 20);
    commit();
    goto_pos(0, 0, ok);
    n = 0;
    for (int i = 0; i < 448; i++) begin if (line_irq) n++; @(negedge clk); end
    checks++;
    if (!ok || n != 0) begin failures++; $display("FAIL irq_out_of_range got %0d exp 0", n); end
  endtask

  task automatic test_reset_pending();
    bit ok;
    cfg_write(CFG_HVID, 10);
    commit();
    checks++;
    if (cfg_pending !== 1'b1) begin failures++; $display("FAIL rp_armed got %b exp 1", cfg_pending); end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({cfg_pending, hsync, col} !== {1'b0, 1'b1, HCB'(0)}) begin
      failures++; $display("FAIL rp_reset got pend=%b hs=%b col=%0d exp 0 1 0", cfg_pending, hsync, col);
    end
    reset = 1'b0;
    commit();
    goto_pos(31, 13, ok);
    goto_pos(19, 2, ok);
    checks++;
    if ({ok, vid_active} !== 2'b11) begin failures++; $display("FAIL rp_shadow_col19 got vid=%b exp 1", vid_active); end
    goto_pos(20, 2, ok);
    checks++;
    if ({ok, vid_active, bdr_active, hsync} !== 4'b1011) begin
      failures++; $display("FAIL rp_shadow_col20 got vid=%b bdr=%b hs=%b exp 0 1 1", vid_active, bdr_active, hsync);
    end
  endtask

  initial begin
    test_reset();
    test_hline();
    test_vcol();
    test_frame_start();
    test_bad_commit();
    test_commit();
    test_commit_on_wrap();
    test_polarity();
    test_line_irq();
    test_reset_pending();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
